l3_bus_sequencer: RTL and testbench
===================================

// Module: l3_bus_sequencer
// PURPOSE
//  Split-transaction snooping bus controller between the four Exclusive_L1L2 cores and the shared L3.
//  Arbitrates core requests round-robin and drives one transaction at a time on the shared bus:
//  address beat, snoop window, then 4 data beats (word0..word3).
//  Collects MESI snoop responses, picks the data source (L3, or a cache-to-cache transfer from an M owner),
//  and reports the fill state to the requester.
// PARAMETERS
//  NUM_CORES  4   requesting cores; core id width = $clog2(NUM_CORES)
//  ADDR_W     32  line address width (bus id bits carried separately on bus_src)
//  WORD_W     32  data beat width
//  BEATS      4   data beats per 128-bit line
// PORTS
//  clk          in   1                clock; all state updates on rising edge
//  rstN         in   1                asynchronous active-low reset
//  req          in   NUM_CORES        per-core request level; held until matching done pulse
//  cmd          in   2*NUM_CORES      per-core command: GETS=0, GETX=1, INV=2, PUTX=3
//  addr         in   ADDR_W*NUM_CORES per-core line address
//  wdata        in   WORD_W*NUM_CORES per-core PUTX writeback word, indexed by beat
//  grant        out  NUM_CORES        one-hot owner; held for whole transaction
//  beat         out  2                current data beat index
//  bus_tag      out  2                IDLE=0, ADDR=1, DATA=2
//  bus_src      out  2                owner core id
//  bus_cmd      out  2                owner command, valid when bus_tag!=IDLE
//  bus_addr     out  ADDR_W           owner address, valid when bus_tag!=IDLE
//  bus_data     out  WORD_W           data beat, valid when bus_tag==DATA
//  snoop_share  in   NUM_CORES        core holds line S/E, sampled in SNOOP
//  snoop_dirty  in   NUM_CORES        core holds line M and will supply data
//  snoop_data   in   WORD_W           cache-to-cache beat from dirty owner
//  l3_req       out  1                L3 access strobe
//  l3_we        out  1                L3 write beat
//  l3_addr      out  ADDR_W           L3 line address
//  l3_wdata     out  WORD_W           L3 write data
//  l3_ready     in   1                L3 accepts request/beat this cycle
//  l3_rvalid    in   1                L3 read beat valid on l3_rdata
//  l3_rdata     in   WORD_W           L3 read beat
//  done         out  NUM_CORES        one-cycle completion pulse to owner
//  fill_state   out  2                MESI for requester fill (I=0,S=1,E=2,M=3), valid with done
// BEHAVIOUR
//  Reset: FSM=IDLE, arbiter pointer=core 0; all outputs 0 (bus_tag=IDLE, grant=0, done=0, l3_req=0).
//    Reset mid-transaction aborts with no done pulse.
//  FSM: IDLE -> ADDR -> SNOOP -> {DATA | WB | FIN} -> IDLE.
//  IDLE: any req -> latch winner, its cmd and addr; grant asserted the next cycle with bus_tag=ADDR.
//  ADDR: 1 cycle broadcast (bus_tag=ADDR), then SNOOP.
//  SNOOP: 1 cycle; sample snoop_share and snoop_dirty with the owner's own bit masked.
//    cmd=INV -> FIN.
//    cmd=PUTX -> WB.
//    otherwise -> DATA.
//  DATA, source selected at SNOOP:
//    Any dirty sharer: beats come from snoop_data, one per cycle. Each beat is also written to L3
//      (l3_we=1); a beat advances only when l3_ready=1.
//    No dirty sharer: one read strobe (l3_req=1, l3_we=0) held until l3_ready; beats advance on l3_rvalid.
//    bus_tag=DATA only on cycles where the beat is valid.
//  WB: owner wdata beats driven to bus and L3 (l3_we=1); advance on l3_ready.
//  Beat counter: 2-bit, wraps after beat BEATS-1 -> FIN.
//  FIN: done[owner]=1 for one cycle, grant drops, arbiter pointer advances past owner, -> IDLE.
//    Earliest back-to-back transaction starts in the ADDR cycle after the next IDLE.
//  fill_state:
//    GETS -> S if any masked share/dirty, else E.
//    GETX/INV -> M.
//    PUTX -> I.
//  Cores other than the owner see bus_cmd GETX/INV and invalidate (their own snooper's job).
//  Req deasserted mid-transaction is ignored; the transaction completes.
//  Simultaneous reqs: round-robin from pointer. A single req is granted immediately.
//  Multiple dirty bits is a protocol error: use the lowest index, assertion fires.
//  Latency with L3 ready every cycle: GETS = 1 (ADDR) + 1 (SNOOP) + 1 (L3 strobe) + 4 (data) + 1 (FIN)
//    = 8 cycles from the first grant cycle to done.
// STRUCTURE
//  bus_pkg: cmd_e, bus_tag_e, mesi_e enums; BEATS and id-width constants.
//    The core snooper and the L3 import the same package.
//  Sub-module: RoundRobinArbiter #(NUM_CORES) for grant selection; its pointer is enabled only in FIN.
//  The FSM, beat counter and snoop latch live in this module.
// TESTING
//  1. Core1 GETS 0x100, no sharers, L3 ready, rvalid 4 cycles, rdata 0xA0..0xA3
//     -> 4 DATA beats 0xA0..0xA3, done[1], fill_state=E, 8 cycles.
//  2. Core0 GETX 0x200 while core2 asserts snoop_dirty, snoop_data 0xD0..0xD3
//     -> bus beats 0xD0..0xD3, 4 L3 writes to 0x200, fill_state=M.
//  3. req=4'b1111 held for 4 transactions -> grant order 0,1,2,3; then pointer wraps to 0.
//  4. Core3 PUTX 0x300 with l3_ready low 2 cycles on beat 1
//     -> beat stalls, 4 writes total, done[3], fill_state=I.
//  5. Core2 INV 0x40, core0 share=1 -> no DATA beats, done[2] 3 cycles after ADDR, fill_state=M.
//  6. rstN low during DATA beat 2 -> outputs 0 immediately, no done; a new req serves from core 0 pointer.

Source files
------------

// File: rtl/l3_bus_sequencer_pkg.sv
// l3_bus_sequencer_pkg: shared bus encodings used by the sequencer, core snoopers and L3.
package l3_bus_sequencer_pkg;
  localparam int CORES = 4;
  localparam int LINE_BEATS = 4;
  localparam int CORE_ID_W = $clog2(CORES);
  typedef enum logic [1:0] {CMD_GETS = 2'd0, CMD_GETX = 2'd1, CMD_INV = 2'd2, CMD_PUTX = 2'd3} cmd_e;
  typedef enum logic [1:0] {TAG_IDLE = 2'd0, TAG_ADDR = 2'd1, TAG_DATA = 2'd2} bus_tag_e;
  typedef enum logic [1:0] {MESI_I = 2'd0, MESI_S = 2'd1, MESI_E = 2'd2, MESI_M = 2'd3} mesi_e;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SNOOP, S_DATA, S_WB, S_FIN} state_e;
endpackage

// File: rtl/l3_bus_sequencer_arb.sv
// l3_bus_sequencer_arb: round-robin winner selection; pointer moves past the owner on adv.
module l3_bus_sequencer_arb #(
  parameter int NUM_CORES = 4,
  localparam int ID_W = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] req,
  input  logic                 adv,
  input  logic [ID_W-1:0]      owner,
  output logic [ID_W-1:0]      win_id
);
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] k;
  always_comb begin
    win_id = '0;
    k = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      k = ID_W'((int'(ptr) + i) % NUM_CORES);
      if (req[k]) win_id = k;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (adv) ptr <= ID_W'((int'(owner) + 1) % NUM_CORES);
endmodule

// File: rtl/l3_bus_sequencer.sv
// l3_bus_sequencer: split-transaction snooping bus controller between the cores and the shared L3.
module l3_bus_sequencer
  import l3_bus_sequencer_pkg::*;
#(
  parameter int NUM_CORES = CORES,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int BEATS = LINE_BEATS,
  localparam int ID_W = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [2*NUM_CORES-1:0]      cmd,
  input  logic [ADDR_W*NUM_CORES-1:0] addr,
  input  logic [WORD_W*NUM_CORES-1:0] wdata,
  output logic [NUM_CORES-1:0]        grant,
  output logic [1:0]                  beat,
  output logic [1:0]                  bus_tag,
  output logic [ID_W-1:0]             bus_src,
  output logic [1:0]                  bus_cmd,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [WORD_W-1:0]           bus_data,
  input  logic [NUM_CORES-1:0]        snoop_share,
  input  logic [NUM_CORES-1:0]        snoop_dirty,
  input  logic [WORD_W-1:0]           snoop_data,
  output logic                        l3_req,
  output logic                        l3_we,
  output logic [ADDR_W-1:0]           l3_addr,
  output logic [WORD_W-1:0]           l3_wdata,
  input  logic                        l3_ready,
  input  logic                        l3_rvalid,
  input  logic [WORD_W-1:0]           l3_rdata,
  output logic [NUM_CORES-1:0]        done,
  output logic [1:0]                  fill_state
);
  state_e state_q, state_d;
  cmd_e cmd_q;
  mesi_e fill_q;
  logic [ID_W-1:0] owner_q, win_id;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] beat_q;
  logic dirty_q, strobed_q, adv, strobe, arb_adv;
  logic [NUM_CORES-1:0] own_oh, share_m, dirty_m;
  logic [WORD_W-1:0] own_wdata;
  l3_bus_sequencer_arb #(.NUM_CORES(NUM_CORES)) u_arb (
    .clk(clk), .rst_n(rst_n), .req(req), .adv(arb_adv), .owner(owner_q), .win_id(win_id)
  );
  assign own_oh = NUM_CORES'(1) << owner_q;
  assign share_m = snoop_share & ~own_oh;
  assign dirty_m = snoop_dirty & ~own_oh;
  assign own_wdata = wdata[owner_q*WORD_W +: WORD_W];
  assign beat = beat_q;
  assign bus_src = owner_q;
  assign bus_cmd = cmd_q;
  assign bus_addr = addr_q;
  assign l3_addr = addr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      cmd_q <= CMD_GETS;
      addr_q <= '0;
      beat_q <= '0;
      dirty_q <= 1'b0;
      strobed_q <= 1'b0;
      fill_q <= MESI_I;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && |req) begin
        owner_q <= win_id;
        cmd_q <= cmd_e'(cmd[win_id*2 +: 2]);
        addr_q <= addr[win_id*ADDR_W +: ADDR_W];
      end
      if (state_q == S_SNOOP) begin
        dirty_q <= |dirty_m;
        strobed_q <= 1'b0;
        fill_q <= cmd_q == CMD_GETS ? (|(share_m | dirty_m) ? MESI_S : MESI_E) :
                  cmd_q == CMD_PUTX ? MESI_I : MESI_M;
      end
      if (strobe) strobed_q <= 1'b1;
      if (adv) beat_q <= beat_q + 2'd1;
    end
  // A clean read issues one strobe, then each l3_rvalid is one beat; dirty and WB beats pace on l3_ready.
  always_comb begin
    state_d = state_q;
    adv = 1'b0;
    strobe = 1'b0;
    arb_adv = 1'b0;
    grant = '0;
    bus_tag = TAG_IDLE;
    bus_data = '0;
    l3_req = 1'b0;
    l3_we = 1'b0;
    l3_wdata = '0;
    done = '0;
    fill_state = MESI_I;
    case (state_q)
      S_IDLE: state_d = |req ? S_ADDR : S_IDLE;
      S_ADDR: begin
        grant = own_oh;
        bus_tag = TAG_ADDR;
        state_d = S_SNOOP;
      end
      S_SNOOP: begin
        grant = own_oh;
        state_d = cmd_q == CMD_INV ? S_FIN : cmd_q == CMD_PUTX ? S_WB : S_DATA;
      end
      S_DATA: begin
        grant = own_oh;
        if (dirty_q) begin
          bus_tag = TAG_DATA;
          bus_data = snoop_data;
          l3_req = 1'b1;
          l3_we = 1'b1;
          l3_wdata = snoop_data;
          adv = l3_ready;
        end else if (!strobed_q) begin
          l3_req = 1'b1;
          strobe = l3_ready;
        end else begin
          bus_tag = l3_rvalid ? TAG_DATA : TAG_IDLE;
          bus_data = l3_rvalid ? l3_rdata : '0;
          adv = l3_rvalid;
        end
        state_d = adv && beat_q == 2'(BEATS - 1) ? S_FIN : S_DATA;
      end
      S_WB: begin
        grant = own_oh;
        bus_tag = TAG_DATA;
        bus_data = own_wdata;
        l3_req = 1'b1;
        l3_we = 1'b1;
        l3_wdata = own_wdata;
        adv = l3_ready;
        state_d = adv && beat_q == 2'(BEATS - 1) ? S_FIN : S_WB;
      end
      S_FIN: begin
        grant = own_oh;
        done = own_oh;
        fill_state = fill_q;
        arb_adv = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  a_single_dirty: assert property (@(posedge clk) disable iff (!rst_n)
    state_q == S_SNOOP |-> $onehot0(dirty_m))
    else $error("multiple dirty snoop responses");
endmodule

// File: tb/tb_l3_bus_sequencer.sv
// tb_l3_bus_sequencer: directed scenario tests with hand-computed expectations.
module tb_l3_bus_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] req, snoop_share, snoop_dirty;
  logic [7:0] cmd;
  logic [127:0] addr, wdata;
  logic [31:0] snoop_data, l3_rdata;
  logic l3_ready, l3_rvalid;
  logic [3:0] grant, done;
  logic [1:0] beat, bus_tag, bus_src, bus_cmd, fill_state;
  logic [31:0] bus_addr, bus_data, l3_addr, l3_wdata;
  logic l3_req, l3_we;
  int checks = 0, errors = 0;

  l3_bus_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
    .grant(grant), .beat(beat), .bus_tag(bus_tag), .bus_src(bus_src), .bus_cmd(bus_cmd),
    .bus_addr(bus_addr), .bus_data(bus_data), .snoop_share(snoop_share), .snoop_dirty(snoop_dirty),
    .snoop_data(snoop_data), .l3_req(l3_req), .l3_we(l3_we), .l3_addr(l3_addr), .l3_wdata(l3_wdata),
    .l3_ready(l3_ready), .l3_rvalid(l3_rvalid), .l3_rdata(l3_rdata), .done(done), .fill_state(fill_state)
  );

  always #5 clk = ~clk;

  task automatic test_reset;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'd0 || bus_tag !== 2'd0 || done !== 4'd0 || l3_req !== 1'b0 || beat !== 2'd0 || fill_state !== 2'd0) begin
      errors++;
      $display("FAIL reset grant=%b tag=%0d done=%b l3_req=%b beat=%0d fill=%0d expected all 0", grant, bus_tag, done, l3_req, beat, fill_state);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (bus_tag !== 2'd0 || grant !== 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset tag=%0d grant=%b expected 0 0", bus_tag, grant);
    end
  endtask

  task automatic test_round_robin;
    bit found;
    int ex;
    @(negedge clk);
    req = 4'b1111; cmd = 8'b10101010;
    addr = {32'h1c0, 32'h180, 32'h140, 32'h100};
    for (int t = 0; t < 5; t++) begin
      ex = t % 4;
      found = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk); #1;
        if (bus_tag === 2'd1) begin found = 1; break; end
      end
      checks++;
      if (!found || grant !== (4'b1 << ex) || bus_src !== 2'(ex)) begin
        errors++;
        $display("FAIL rr_grant%0d found=%0d grant=%b src=%0d expected grant=%b src=%0d", t, found, grant, bus_src, 4'b1 << ex, ex);
      end
      for (int c = 0; c < 10; c++) begin
        @(negedge clk); #1;
        if (done !== 4'd0) break;
      end
      checks++;
      if (done !== (4'b1 << ex) || fill_state !== 2'd3) begin
        errors++;
        $display("FAIL rr_done%0d done=%b fill=%0d expected %b 3", t, done, fill_state, 4'b1 << ex);
      end
      if (t == 4) req = 4'd0;
    end
    @(negedge clk); cmd = '0;
  endtask

  task automatic test_gets(input int id, input logic [3:0] share, input logic [1:0] exp_fill, input logic [31:0] a);
    @(negedge clk);
    req = 4'b1 << id; cmd[id*2 +: 2] = 2'd0; addr[id*32 +: 32] = a; l3_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (grant !== (4'b1 << id) || bus_tag !== 2'd1 || bus_addr !== a || bus_src !== 2'(id) || bus_cmd !== 2'd0) begin
      errors++;
      $display("FAIL gets_addr grant=%b tag=%0d addr=%h src=%0d cmd=%0d expected %b 1 %h %0d 0", grant, bus_tag, bus_addr, bus_src, bus_cmd, 4'b1 << id, a, id);
    end
    @(negedge clk); snoop_share = share;
    @(negedge clk); snoop_share = 4'd0; #1;
    checks++;
    if (l3_req !== 1'b1 || l3_we !== 1'b0 || l3_addr !== a || bus_tag !== 2'd0) begin
      errors++;
      $display("FAIL gets_strobe req=%b we=%b addr=%h tag=%0d expected 1 0 %h 0", l3_req, l3_we, l3_addr, bus_tag, a);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); l3_rvalid = 1'b1; l3_rdata = 32'ha0 + k; #1;
      checks++;
      if (bus_tag !== 2'd2 || bus_data !== 32'ha0 + k || beat !== 2'(k) || done !== 4'd0) begin
        errors++;
        $display("FAIL gets_beat%0d tag=%0d data=%h beat=%0d done=%b expected 2 %h %0d 0", k, bus_tag, bus_data, beat, done, 32'ha0 + k, k);
      end
    end
    @(negedge clk); l3_rvalid = 1'b0; #1;
    checks++;
    if (done !== (4'b1 << id) || fill_state !== exp_fill) begin
      errors++;
      $display("FAIL gets_done done=%b fill=%0d expected %b %0d", done, fill_state, 4'b1 << id, exp_fill);
    end
    req = 4'd0;
    @(negedge clk); #1;
    checks++;
    if (done !== 4'd0 || bus_tag !== 2'd0 || grant !== 4'd0) begin
      errors++;
      $display("FAIL gets_idle done=%b tag=%0d grant=%b expected 0 0 0", done, bus_tag, grant);
    end
  endtask

  task automatic test_getx_dirty;
    int writes = 0;
    @(negedge clk);
    req = 4'b0001; cmd[1:0] = 2'd1; addr[31:0] = 32'h200; l3_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0001 || bus_tag !== 2'd1 || bus_cmd !== 2'd1) begin
      errors++;
      $display("FAIL getx_addr grant=%b tag=%0d cmd=%0d expected 0001 1 1", grant, bus_tag, bus_cmd);
    end
    @(negedge clk); snoop_dirty = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); snoop_dirty = 4'd0; snoop_data = 32'hd0 + k; #1;
      if (l3_req && l3_we && l3_ready) writes++;
      checks++;
      if (bus_tag !== 2'd2 || bus_data !== 32'hd0 + k || l3_we !== 1'b1 || l3_addr !== 32'h200 || l3_wdata !== 32'hd0 + k) begin
        errors++;
        $display("FAIL getx_beat%0d tag=%0d data=%h we=%b l3_addr=%h l3_wdata=%h expected 2 %h 1 200 %h", k, bus_tag, bus_data, l3_we, l3_addr, l3_wdata, 32'hd0 + k, 32'hd0 + k);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 4'b0001 || fill_state !== 2'd3 || writes != 4) begin
      errors++;
      $display("FAIL getx_done done=%b fill=%0d writes=%0d expected 0001 3 4", done, fill_state, writes);
    end
    req = 4'd0;
  endtask

  task automatic test_putx_stall;
    int writes = 0;
    int eb;
    logic [5:0] rdy = 6'b111001;
    @(negedge clk);
    req = 4'b1000; cmd[7:6] = 2'd3; addr[127:96] = 32'h300;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b1000 || bus_tag !== 2'd1 || bus_src !== 2'd3) begin
      errors++;
      $display("FAIL putx_addr grant=%b tag=%0d src=%0d expected 1000 1 3", grant, bus_tag, bus_src);
    end
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      eb = (i == 0) ? 0 : (i <= 3) ? 1 : i - 2;
      @(negedge clk); l3_ready = rdy[i]; wdata[127:96] = 32'h30 + eb; #1;
      if (l3_req && l3_we && l3_ready) writes++;
      checks++;
      if (beat !== 2'(eb) || bus_tag !== 2'd2 || bus_data !== 32'h30 + eb || l3_we !== 1'b1 || done !== 4'd0) begin
        errors++;
        $display("FAIL putx_cyc%0d beat=%0d tag=%0d data=%h we=%b done=%b expected %0d 2 %h 1 0", i, beat, bus_tag, bus_data, l3_we, done, eb, 32'h30 + eb);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (done !== 4'b1000 || fill_state !== 2'd0 || writes != 4) begin
      errors++;
      $display("FAIL putx_done done=%b fill=%0d writes=%0d expected 1000 0 4", done, fill_state, writes);
    end
    req = 4'd0;
  endtask

  task automatic test_inv;
    @(negedge clk);
    req = 4'b0100; cmd[5:4] = 2'd2; addr[95:64] = 32'h40;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0100 || bus_tag !== 2'd1 || bus_cmd !== 2'd2 || bus_addr !== 32'h40) begin
      errors++;
      $display("FAIL inv_addr grant=%b tag=%0d cmd=%0d addr=%h expected 0100 1 2 40", grant, bus_tag, bus_cmd, bus_addr);
    end
    @(negedge clk); snoop_share = 4'b0001; #1;
    checks++;
    if (bus_tag === 2'd2 || done !== 4'd0) begin
      errors++;
      $display("FAIL inv_snoop tag=%0d done=%b expected non-data 0", bus_tag, done);
    end
    @(negedge clk); snoop_share = 4'd0; #1;
    checks++;
    if (done !== 4'b0100 || fill_state !== 2'd3 || bus_tag !== 2'd0) begin
      errors++;
      $display("FAIL inv_done done=%b fill=%0d tag=%0d expected 0100 3 0", done, fill_state, bus_tag);
    end
    req = 4'd0;
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    cmd = '0; req = 4'b1000; addr[127:96] = 32'h500; l3_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); l3_rvalid = 1'b1; l3_rdata = 32'hb0 + k;
    end
    #1;
    checks++;
    if (beat !== 2'd2 || bus_tag !== 2'd2) begin
      errors++;
      $display("FAIL abort_pre beat=%0d tag=%0d expected 2 2", beat, bus_tag);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (grant !== 4'd0 || bus_tag !== 2'd0 || done !== 4'd0 || l3_req !== 1'b0 || beat !== 2'd0) begin
      errors++;
      $display("FAIL abort_reset grant=%b tag=%0d done=%b l3_req=%b beat=%0d expected all 0", grant, bus_tag, done, l3_req, beat);
    end
    @(negedge clk); l3_rvalid = 1'b0; rst_n = 1'b1; req = 4'b1001;
    @(negedge clk); #1;
    checks++;
    if (grant !== 4'b0001 || bus_src !== 2'd0 || bus_tag !== 2'd1 || done !== 4'd0) begin
      errors++;
      $display("FAIL abort_regrant grant=%b src=%0d tag=%0d done=%b expected 0001 0 1 0", grant, bus_src, bus_tag, done);
    end
    req = 4'd0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    req = '0; cmd = '0; addr = '0; wdata = '0; snoop_share = '0; snoop_dirty = '0;
    snoop_data = '0; l3_ready = 1'b0; l3_rvalid = 1'b0; l3_rdata = '0;
    test_reset;
    test_round_robin;
    test_gets(1, 4'b0000, 2'd2, 32'h100);
    test_gets(2, 4'b0001, 2'd1, 32'h140);
    test_gets(1, 4'b0010, 2'd2, 32'h180);
    test_getx_dirty;
    test_putx_stall;
    test_inv;
    test_reset_abort;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
